// File: rtl/dot_pkg.sv
// Shared definitions for the dot-matrix scroller: mode encodings, default geometry
// and the glyph/phase types used across the display datapath.
package dot_pkg;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_SCROLL = 2'b10;

  localparam int unsigned DEF_N_COL = 5;
  localparam int unsigned DEF_N_ROW = 7;

  typedef logic [3:0] glyph_t;

  typedef enum logic {PhVisible, PhHidden} phase_e;

endpackage

// File: rtl/dot_glyph_rom.sv
// Combinational 5x7 digit font. Each column is 7 bits with bit0 the top row;
// glyph 0, unused glyphs and columns beyond the font width read as blank.
module dot_glyph_rom
  import dot_pkg::*;
#(
  parameter int unsigned N_ROW = DEF_N_ROW,
  parameter int unsigned IDX_W = 4
) (
  input  glyph_t             glyph,
  input  logic [IDX_W-1:0]   column,
  output logic [N_ROW-1:0]   bits
);

  logic [34:0] font;
  logic [6:0]  cols [5];
  logic [6:0]  col_bits;

  // Packed as {col0, col1, col2, col3, col4}.
  always_comb begin
    unique case (glyph)
      4'd1:    font = {7'h00, 7'h42, 7'h7F, 7'h7F, 7'h40};
      4'd2:    font = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
      4'd3:    font = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
      4'd4:    font = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
      4'd5:    font = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
      4'd6:    font = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
      4'd7:    font = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
      4'd8:    font = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      default: font = '0;
    endcase
  end

  always_comb begin
    col_bits = '0;
    for (int unsigned c = 0; c < 5; c++) begin
      cols[c] = font[(4-c)*7 +: 7];
      if (column == IDX_W'(c)) col_bits = cols[c];
    end
  end

  assign bits = N_ROW'(col_bits);

endmodule

// File: rtl/dot_matrix_scroller.sv
// Column-scanning LED matrix driver: one-cold column scan, switch-selected glyph,
// static/blink/scroll-left presentation updated only on frame boundaries.
module dot_matrix_scroller
  import dot_pkg::*;
#(
  parameter int unsigned N_COL     = DEF_N_COL,
  parameter int unsigned N_ROW     = DEF_N_ROW,
  parameter int unsigned N_SW      = 8,
  parameter int unsigned SCAN_DIV  = 5400,
  parameter int unsigned FRAME_DIV = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SW-1:0]   dipsw,
  input  logic [1:0]        mode,
  output logic [1:0]        portA,
  output logic [1:0]        portB,
  output logic [N_ROW-1:0]  row,
  output logic [N_COL-1:0]  col
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrameW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned ColW   = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int unsigned OffW   = $clog2(2 * N_COL);

  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(FRAME_DIV - 1);
  localparam logic [OffW:0]     Span      = (OffW + 1)'(2 * N_COL);

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [N_COL-1:0]  col_q, col_d;
  logic [ColW-1:0]   col_idx_q, col_idx_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic [OffW-1:0]   offset_q, offset_d;
  phase_e            phase_q, phase_d;
  glyph_t            glyph_q, glyph_d;
  logic [1:0]        mode_q, mode_d;
  logic [N_ROW-1:0]  row_q, row_d;
  logic [1:0]        port_q;

  logic              tick, frame_bnd, col_ok;
  logic [N_COL-1:0]  col_inv;
  glyph_t            sw_glyph;
  logic [OffW:0]     off_inc, vsum;
  logic [OffW-1:0]   vcol;
  logic [N_ROW-1:0]  rom_bits;

  assign tick    = (scan_cnt_q == ScanLast);
  assign col_inv = ~col_q;
  // Shift only from a clean one-cold pattern whose zero has not reached the top bit.
  assign col_ok  = (col_inv != '0) && ((col_inv & (col_inv - N_COL'(1))) == '0)
                   && col_q[N_COL-1];

  always_comb begin
    scan_cnt_d = tick ? '0 : scan_cnt_q + 1'b1;
    col_d      = col_q;
    col_idx_d  = col_idx_q;
    if (tick) begin
      if (col_ok) begin
        col_d     = {col_q[N_COL-2:0], 1'b1};
        col_idx_d = col_idx_q + 1'b1;
      end else begin
        col_d     = ~N_COL'(1);
        col_idx_d = '0;
      end
    end
  end

  assign frame_bnd = tick && (col_idx_d == '0);

  // Lowest set switch wins.
  always_comb begin
    sw_glyph = '0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (dipsw[i]) sw_glyph = glyph_t'(i + 1);
    end
  end

  always_comb begin
    glyph_d     = glyph_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    offset_d    = offset_q;
    phase_d     = phase_q;
    off_inc     = {1'b0, offset_q} + 1'b1;
    if (off_inc >= Span) off_inc = off_inc - Span;
    if (frame_bnd) begin
      glyph_d = sw_glyph;
      mode_d  = mode;
      if ((sw_glyph != glyph_q) || (mode != mode_q)) begin
        frame_cnt_d = '0;
        offset_d    = '0;
        phase_d     = PhVisible;
      end else if (frame_cnt_q == FrameLast) begin
        frame_cnt_d = '0;
        if (mode_q == MODE_BLINK) begin
          phase_d = (phase_q == PhVisible) ? PhHidden : PhVisible;
        end else if (mode_q == MODE_SCROLL) begin
          offset_d = OffW'(off_inc);
        end
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Row is built from next-state values so it lands on the same edge as col.
  always_comb begin
    vsum = (OffW + 1)'(col_idx_d);
    if (mode_d == MODE_SCROLL) vsum = vsum + {1'b0, offset_d};
    if (vsum >= Span) vsum = vsum - Span;
    vcol = OffW'(vsum);
  end

  dot_glyph_rom #(
    .N_ROW (N_ROW),
    .IDX_W (OffW)
  ) u_rom (
    .glyph  (glyph_d),
    .column (vcol),
    .bits   (rom_bits)
  );

  always_comb begin
    row_d = row_q;
    if (tick) begin
      row_d = '0;
      if ((vcol < OffW'(N_COL)) && (phase_d == PhVisible) && (glyph_d != '0)) begin
        row_d = rom_bits;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      col_q       <= '0;
      col_idx_q   <= '0;
      frame_cnt_q <= '0;
      offset_q    <= '0;
      phase_q     <= PhVisible;
      glyph_q     <= '0;
      mode_q      <= MODE_STATIC;
      row_q       <= '0;
      port_q      <= 2'b00;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      col_q       <= col_d;
      col_idx_q   <= col_idx_d;
      frame_cnt_q <= frame_cnt_d;
      offset_q    <= offset_d;
      phase_q     <= phase_d;
      glyph_q     <= glyph_d;
      mode_q      <= mode_d;
      row_q       <= row_d;
      port_q      <= 2'b01;
    end
  end

  assign portA = port_q;
  assign portB = port_q;
  assign row   = row_q;
  assign col   = col_q;

endmodule

// File: tb/tb_dot_matrix_scroller.sv
// Bench for dot_matrix_scroller: a time-based display model checked every cycle,
// plus directed scenarios with hand-computed row/column values.
module tb_dot_matrix_scroller;

  localparam int SD = 4;
  localparam int FD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dipsw = 8'h00;
  logic [1:0] mode = 2'b00;
  logic [1:0] portA, portB;
  logic [6:0] row;
  logic [4:0] col;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: edges since release, frame index of last glyph/mode change.
  int         k = 0;
  int         fc = -1;
  int         cur_glyph = 0;
  logic [1:0] cur_mode = 2'b00;
  bit         port_on = 1'b0;

  dot_matrix_scroller #(
    .N_COL     (5),
    .N_ROW     (7),
    .N_SW      (8),
    .SCAN_DIV  (SD),
    .FRAME_DIV (FD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dipsw (dipsw),
    .mode  (mode),
    .portA (portA),
    .portB (portB),
    .row   (row),
    .col   (col)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] font(input int g, input int c);
    logic [34:0] t;
    case (g)
      1: t = {7'h00, 7'h42, 7'h7F, 7'h7F, 7'h40};
      2: t = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
      3: t = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
      4: t = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
      5: t = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
      6: t = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
      7: t = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
      8: t = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      default: t = '0;
    endcase
    return t[(4 - c) * 7 +: 7];
  endfunction

  function automatic logic [6:0] model_row(input int idx, input int f);
    int s, v;
    if (cur_glyph == 0) return 7'h00;
    s = (f - fc) / FD;
    v = idx;
    if (cur_mode == 2'b01 && (s % 2) == 1) return 7'h00;
    if (cur_mode == 2'b10) v = (idx + s) % 10;
    if (v >= 5) return 7'h00;
    return font(cur_glyph, v);
  endfunction

  // Model update: latches switches at each frame start.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      k = 0; fc = -1; cur_glyph = 0; cur_mode = 2'b00; port_on = 1'b0;
    end else begin
      int m, g;
      k++;
      port_on = 1'b1;
      m = k / SD;
      if ((k % SD) == 0 && ((m - 1) % 5) == 0) begin
        g = 0;
        for (int i = 0; i < 8; i++) begin
          if (dipsw[i]) begin g = i + 1; break; end
        end
        if (g != cur_glyph || mode != cur_mode) begin
          cur_glyph = g; cur_mode = mode; fc = (m - 1) / 5;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    int m, idx;
    logic [4:0] ecol;
    logic [6:0] erow;
    @(negedge clk);
    m = k / SD;
    if (m == 0) begin
      ecol = 5'b00000; erow = 7'h00;
    end else begin
      idx = (m - 1) % 5;
      ecol = ~(5'b00001 << idx);
      erow = model_row(idx, (m - 1) / 5);
    end
    check("model col", {27'd0, col}, {27'd0, ecol});
    check("model row", {25'd0, row}, {25'd0, erow});
    check("model port", {28'd0, portA, portB}, port_on ? 32'h5 : 32'h0);
  end

  task automatic wait_col(input logic [4:0] target);
    int n = 0;
    do begin @(negedge clk); n++; end while (col !== target && n < 100);
    check("reach col", {27'd0, col}, {27'd0, target});
  endtask

  task automatic next_frame();
    int n = 0;
    logic [4:0] prev;
    forever begin
      prev = col;
      @(negedge clk);
      n++;
      if ((col === 5'b11110 && prev !== 5'b11110) || n >= 100) break;
    end
    check("frame start", {27'd0, col}, 32'h1E);
  endtask

  logic [4:0] seq [6];

  initial begin
    seq[0] = 5'b11110; seq[1] = 5'b11101; seq[2] = 5'b11011;
    seq[3] = 5'b10111; seq[4] = 5'b01111; seq[5] = 5'b11110;
    repeat (3) @(negedge clk);
    check("reset col", {27'd0, col}, 32'h0);
    check("reset port", {28'd0, portA, portB}, 32'h0);

    // Scan sequence with blank glyph.
    reset = 1'b1;
    @(posedge clk); #1;
    check("portA after release", {30'd0, portA}, 32'h1);
    check("portB after release", {30'd0, portB}, 32'h1);
    check("col before first tick", {27'd0, col}, 32'h0);
    repeat (3) @(posedge clk); #1;
    check("col step 0", {27'd0, col}, {27'd0, seq[0]});
    for (int i = 1; i < 6; i++) begin
      repeat (SD) @(posedge clk); #1;
      check("col step", {27'd0, col}, {27'd0, seq[i]});
      check("blank row", {25'd0, row}, 32'h0);
    end

    // Digit 1 static.
    @(negedge clk); dipsw = 8'h01;
    next_frame();
    check("d1 col0", {25'd0, row}, 32'h00);
    wait_col(5'b11011);
    check("d1 col2", {25'd0, row}, 32'h7F);
    next_frame();
    check("d1 col0 again", {25'd0, row}, 32'h00);
    wait_col(5'b11011);
    check("d1 col2 again", {25'd0, row}, 32'h7F);

    // Priority and mid-frame change.
    @(negedge clk); dipsw = 8'h81;
    next_frame();
    wait_col(5'b11101);
    check("prio d1 col1", {25'd0, row}, 32'h42);
    dipsw = 8'h80;
    wait_col(5'b10111);
    check("no tearing col3", {25'd0, row}, 32'h7F);
    next_frame();
    check("d8 col0", {25'd0, row}, 32'h36);
    wait_col(5'b11101);
    check("d8 col1", {25'd0, row}, 32'h49);

    // Blink: two frames on, two off.
    @(negedge clk); mode = 2'b01;
    for (int i = 0; i < 6; i++) begin
      next_frame();
      check("blink col0", {25'd0, row}, (i == 2 || i == 3) ? 32'h00 : 32'h36);
    end

    // Scroll digit 1; one step per FD frames.
    @(negedge clk); dipsw = 8'h01; mode = 2'b10;
    next_frame();
    check("scroll off0 col0", {25'd0, row}, 32'h00);
    for (int e = 1; e <= 20; e++) begin
      next_frame();
      if (e == 2) check("scroll off1 col0", {25'd0, row}, 32'h42);
      if (e == 10) begin
        check("scroll off5 col0", {25'd0, row}, 32'h00);
        wait_col(5'b11011);
        check("scroll off5 col2", {25'd0, row}, 32'h00);
      end
      if (e == 20) begin
        check("scroll wrap col0", {25'd0, row}, 32'h00);
        wait_col(5'b11011);
        check("scroll wrap col2", {25'd0, row}, 32'h7F);
      end
    end

    // Asynchronous reset mid-frame.
    wait_col(5'b10111);
    #1 reset = 1'b0;
    #1;
    check("async reset col", {27'd0, col}, 32'h0);
    check("async reset row", {25'd0, row}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    next_frame();
    check("post reset col0", {25'd0, row}, 32'h00);
    wait_col(5'b10111);
    check("post reset offset0 col3", {25'd0, row}, 32'h7F);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
